// File: rtl/arm_if_pkg.sv
// Shared types and constants for the instruction fetch stage.
package arm_if_pkg;

   // Fetch sequencer states; at most one imem request is ever in flight.
   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DRAIN,
      S_STALL
   } if_state_e;

   // Sequential fetch step in bytes.
   localparam int PC_INC       = 4;
   // Branch targets are relative to the branch PC plus two words.
   localparam int BR_PC_OFFSET = 8;

endpackage

// File: rtl/if_out_buf.sv
// Output stage of instruction fetch: the register decode sees, plus a
// one-entry skid register for a word that lands while decode is stalled.
module if_out_buf
   import arm_if_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              push,
   input  logic [31:0]       push_instr,
   input  logic [ADDR_W-1:0] push_pc,
   input  logic              if_ready,
   output logic              if_valid,
   output logic [31:0]       if_instr,
   output logic [ADDR_W-1:0] if_pc,
   output logic              slot_free
);

   logic              out_vld_q, out_vld_d;
   logic [31:0]       out_instr_q, out_instr_d;
   logic [ADDR_W-1:0] out_pc_q, out_pc_d;
   logic              skd_vld_q, skd_vld_d;
   logic [31:0]       skd_instr_q, skd_instr_d;
   logic [ADDR_W-1:0] skd_pc_q, skd_pc_d;

   // The output slot can take a new word if it is empty or being consumed now.
   assign slot_free = !out_vld_q || if_ready;

   // Next-state for output and skid registers; a flush drops both entries.
   always_comb begin
      out_vld_d   = out_vld_q;
      out_instr_d = out_instr_q;
      out_pc_d    = out_pc_q;
      skd_vld_d   = skd_vld_q;
      skd_instr_d = skd_instr_q;
      skd_pc_d    = skd_pc_q;
      if (flush) begin
         out_vld_d = 1'b0;
         skd_vld_d = 1'b0;
      end else if (push) begin
         if (slot_free) begin
            out_vld_d   = 1'b1;
            out_instr_d = push_instr;
            out_pc_d    = push_pc;
         end else begin
            skd_vld_d   = 1'b1;
            skd_instr_d = push_instr;
            skd_pc_d    = push_pc;
         end
      end else if (if_ready) begin
         // Consumed word is replaced by the skid entry if one is waiting.
         out_vld_d = skd_vld_q;
         if (skd_vld_q) begin
            out_instr_d = skd_instr_q;
            out_pc_d    = skd_pc_q;
         end
         skd_vld_d = 1'b0;
      end
   end

   // Register update with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_vld_q   <= 1'b0;
         out_instr_q <= '0;
         out_pc_q    <= '0;
         skd_vld_q   <= 1'b0;
         skd_instr_q <= '0;
         skd_pc_q    <= '0;
      end else begin
         out_vld_q   <= out_vld_d;
         out_instr_q <= out_instr_d;
         out_pc_q    <= out_pc_d;
         skd_vld_q   <= skd_vld_d;
         skd_instr_q <= skd_instr_d;
         skd_pc_q    <= skd_pc_d;
      end
   end

   assign if_valid = out_vld_q;
   assign if_instr = out_instr_q;
   assign if_pc    = out_pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Multi-cycle instruction fetch: PC, request sequencer and branch redirect.
// Optional feature macro IF_PERF_CNT_EN adds fetched/stall performance counters.
module instr_fetch
   import arm_if_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic              if_valid,
   input  logic              if_ready,
   output logic [31:0]       if_instr,
   output logic [ADDR_W-1:0] if_pc,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_pc,
   input  logic [31:0]       br_imm
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]       perf_fetched,
   output logic [31:0]       perf_stall
`endif
);

   if_state_e         state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] br_tgt;
   logic              push;
   logic              slot_free;

   // Redirect target, word aligned, modular add (negative offsets wrap).
   always_comb begin
      br_tgt = br_pc + ADDR_W'(BR_PC_OFFSET) + ADDR_W'(br_imm);
      br_tgt = {br_tgt[ADDR_W-1:2], 2'b00};
   end

   // Sequencer next state and PC; a branch overrides everything else.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      push    = 1'b0;
      case (state_q)
         S_IDLE:  state_d = S_REQ;
         S_REQ:   state_d = S_WAIT;
         S_WAIT: begin
            if (imem_ack) begin
               push    = 1'b1;
               pc_d    = pc_q + ADDR_W'(PC_INC);
               state_d = slot_free ? S_REQ : S_STALL;
            end
         end
         S_STALL: if (if_ready) state_d = S_REQ;
         S_DRAIN: if (imem_ack) state_d = S_REQ;
         default: state_d = S_IDLE;
      endcase
      if (br_taken) begin
         push = 1'b0;
         pc_d = br_tgt;
         case (state_q)
            S_REQ:   state_d = S_DRAIN;
            // An ack arriving with the redirect closes the stale request.
            S_WAIT,
            S_DRAIN: state_d = imem_ack ? S_REQ : S_DRAIN;
            default: state_d = S_REQ;
         endcase
      end
   end

   // State and PC registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   assign imem_req  = (state_q == S_REQ);
   assign imem_addr = imem_req ? pc_q : '0;

   if_out_buf #(.ADDR_W(ADDR_W)) u_out_buf (
      .clk        (clk),
      .reset_n    (reset_n),
      .flush      (br_taken),
      .push       (push),
      .push_instr (imem_rdata),
      .push_pc    (pc_q),
      .if_ready   (if_ready),
      .if_valid   (if_valid),
      .if_instr   (if_instr),
      .if_pc      (if_pc),
      .slot_free  (slot_free)
   );

`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetched_q, perf_fetched_d;
   logic [31:0] perf_stall_q, perf_stall_d;

   // Count accepted (non-void) handshakes and decode back-pressure cycles.
   always_comb begin
      perf_fetched_d = perf_fetched_q;
      perf_stall_d   = perf_stall_q;
      if (if_valid && if_ready && !br_taken) perf_fetched_d = perf_fetched_q + 32'd1;
      if (if_valid && !if_ready)             perf_stall_d   = perf_stall_q + 32'd1;
   end

   // Counter registers, wrapping naturally at 2^32.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         perf_fetched_q <= '0;
         perf_stall_q   <= '0;
      end else begin
         perf_fetched_q <= perf_fetched_d;
         perf_stall_q   <= perf_stall_d;
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_stall   = perf_stall_q;
`else
   // Performance counters not built in this configuration.
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios, a branch-vector table and a
// randomized phase, all checked against a word-stream model of fetch.
module tb_instr_fetch;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        if_valid;
   logic        if_ready = 1'b0;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        br_taken = 1'b0;
   logic [31:0] br_pc = '0;
   logic [31:0] br_imm = '0;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_stall;
`endif

   always #5 clk = ~clk;

   instr_fetch #(.ADDR_W(32), .RESET_PC(RST_PC)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .if_valid   (if_valid),
      .if_ready   (if_ready),
      .if_instr   (if_instr),
      .if_pc      (if_pc),
      .br_taken   (br_taken),
      .br_pc      (br_pc),
      .br_imm     (br_imm)
`ifdef IF_PERF_CNT_EN
      ,
      .perf_fetched (perf_fetched),
      .perf_stall   (perf_stall)
`endif
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A3C_96E1;
   endfunction

   function automatic logic [31:0] br_target(input logic [31:0] bpc, input logic [31:0] bimm);
      logic [31:0] t;
      t = bpc + 32'd8 + bimm;
      return t & 32'hFFFF_FFFC;
   endfunction

   // Model: words owed to decode, in order, and where the next fetch must go.
   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } word_t;
   word_t       q[$];
   logic [31:0] exp_addr = '0;
   bit          outst = 0;
   bit          stale = 0;
   logic [31:0] out_addr = '0;
   bit          live = 0;
   logic [31:0] m_fetched = '0;
   logic [31:0] m_stall = '0;
   bit          pcheck = 0;

   // Memory responder.
   bit          pend = 0;
   int          pcnt = 0;
   logic [31:0] paddr = '0;
   int          lat = 1;

   // Per-cycle observations.
   int          cyc = 0;
   bit          saw_req, saw_hs, saw_br, saw_v;
   logic [31:0] req_addr, hs_pc;

   task automatic tick(input bit rdy, input bit rst, input int brmode,
                       input logic [31:0] bpc, input logic [31:0] bimm);
      bit ack, br, v, onow, hs;
      logic [31:0] rd;
      @(negedge clk);
      cyc++;
      v        = (if_valid === 1'b1);
      saw_v    = v;
      saw_req  = (imem_req === 1'b1);
      req_addr = imem_addr;
      hs_pc    = if_pc;
      if (live) begin
         chk("if_valid", 32'(if_valid), 32'(q.size() != 0));
         if (v && q.size() != 0) begin
            chk("if_instr", if_instr, q[0].instr);
            chk("if_pc", if_pc, q[0].pc);
         end
         if (saw_req) begin
            chk("imem_addr", imem_addr, exp_addr);
            chk("req_while_outstanding", 32'(outst), 32'd0);
            chk("req_with_full_buffer", 32'(q.size() >= 2), 32'd0);
         end
         if (pcheck) begin
`ifdef IF_PERF_CNT_EN
            chk("perf_fetched", perf_fetched, m_fetched);
            chk("perf_stall", perf_stall, m_stall);
`endif
            pcheck = 0;
         end
      end
      ack = 0;
      rd  = 32'hDEAD_BEEF;
      if (pend) begin
         pcnt--;
         if (pcnt <= 0) begin
            ack  = 1;
            rd   = mem_word(paddr);
            pend = 0;
         end
      end
      if (saw_req) begin
         pend  = 1;
         pcnt  = lat;
         paddr = imem_addr;
      end
      onow = outst || (live && saw_req);
      br = !rst && (brmode == 1 || (brmode == 2 && ack) || (brmode == 3 && onow && !ack));
      imem_ack   = ack;
      imem_rdata = rd;
      if_ready   = rdy;
      br_taken   = br;
      br_pc      = bpc;
      br_imm     = bimm;
      reset_n    = !rst;
      hs = 0;
      if (rst) begin
         q.delete();
         outst = 0;
         stale = 0;
         exp_addr = RST_PC;
         m_fetched = '0;
         m_stall = '0;
         live = 1;
      end else if (live) begin
         hs = v && rdy && !br;
         if (hs) begin
            void'(q.pop_front());
            m_fetched = m_fetched + 32'd1;
         end
         if (v && !rdy) m_stall = m_stall + 32'd1;
         if (ack && outst) begin
            if (!stale && !br) begin
               q.push_back('{rd, out_addr});
               exp_addr = out_addr + 32'd4;
            end
            outst = 0;
         end
         if (saw_req) begin
            outst = 1;
            stale = 0;
            out_addr = req_addr;
         end
         if (br) begin
            q.delete();
            exp_addr = br_target(bpc, bimm);
            if (outst) stale = 1;
         end
      end
      saw_hs = hs;
      saw_br = br;
   endtask

   task automatic run_until_req(output bit ok, output logic [31:0] a);
      ok = 0;
      a  = '0;
      for (int i = 0; i < 20 && !ok; i++) begin
         tick(1, 0, 0, '0, '0);
         if (saw_req) begin
            ok = 1;
            a  = req_addr;
         end
      end
      if (!ok) chk("req_timeout", 32'd0, 32'd1);
   endtask

   typedef struct {
      logic [31:0] bpc;
      logic [31:0] bimm;
      int          mode;
      logic [31:0] exp;
   } brv_t;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected $finish");
      $fatal(1, "timeout");
   end

   initial begin
      brv_t        tv[6];
      int          reqs[$];
      int          hsc[$];
      logic [31:0] pcs[$];
      bit          ok, fired;
      logic [31:0] a;
      int          nreq;

      // mode 1: immediate, 2: same cycle as ack, 3: while ack still pending
      tv[0] = '{32'h0000_0200, 32'hFFFF_FFF0, 3, 32'h0000_01F8};
      tv[1] = '{32'h0000_1000, 32'h0000_0010, 2, 32'h0000_1018};
      tv[2] = '{32'hFFFF_FFF8, 32'h0000_0004, 1, 32'h0000_0004};
      tv[3] = '{32'h0000_0300, 32'hFFFF_FD00, 3, 32'h0000_0008};
      tv[4] = '{32'h0000_0123, 32'h0000_0001, 2, 32'h0000_012C};
      tv[5] = '{32'h0000_0000, 32'hFFFF_FFF4, 1, 32'hFFFF_FFFC};

      // Reset values
      lat = 1;
      tick(1, 1, 0, '0, '0);
      tick(1, 1, 0, '0, '0);
      chk("rst_if_valid", 32'(if_valid), 32'd0);
      chk("rst_if_instr", if_instr, 32'd0);
      chk("rst_if_pc", if_pc, 32'd0);
      chk("rst_imem_req", 32'(imem_req), 32'd0);
      chk("rst_imem_addr", imem_addr, 32'd0);
`ifdef IF_PERF_CNT_EN
      chk("rst_perf_fetched", perf_fetched, 32'd0);
      chk("rst_perf_stall", perf_stall, 32'd0);
`endif

      // Streaming with 1-cycle memory and decode always ready
      for (int i = 0; i < 14; i++) begin
         tick(1, 0, 0, '0, '0);
         if (saw_req) reqs.push_back(int'(req_addr));
         if (saw_hs) hsc.push_back(cyc);
      end
      if (reqs.size() >= 3) begin
         chk("s1_addr0", 32'(reqs[0]), 32'h100);
         chk("s1_addr1", 32'(reqs[1]), 32'h104);
         chk("s1_addr2", 32'(reqs[2]), 32'h108);
      end else chk("s1_req_count", 32'(reqs.size()), 32'd3);
      if (hsc.size() >= 5) begin
         for (int i = 0; i < 4; i++) chk("s1_hs_gap", 32'(hsc[i+1] - hsc[i]), 32'd2);
      end else chk("s1_hs_count", 32'(hsc.size()), 32'd5);
      pcheck = 1;
      tick(1, 0, 0, '0, '0);

      // Decode stalls 5 cycles on the first word; skid holds the second
      tick(1, 1, 0, '0, '0);
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         tick(0, 0, 0, '0, '0);
         ok = saw_v;
      end
      chk("s2_first_word_seen", 32'(ok), 32'd1);
      nreq = int'(saw_req);
      for (int i = 0; i < 4; i++) begin
         tick(0, 0, 0, '0, '0);
         nreq += int'(saw_req);
      end
      chk("s2_reqs_during_stall", 32'(nreq), 32'd1);
      for (int i = 0; i < 14; i++) begin
         tick(1, 0, 0, '0, '0);
         if (saw_hs) pcs.push_back(hs_pc);
      end
      if (pcs.size() >= 4) begin
         for (int i = 0; i < 4; i++) chk("s2_order", pcs[i], RST_PC + 32'(4 * i));
      end else chk("s2_hs_count", 32'(pcs.size()), 32'd4);
      pcheck = 1;
      tick(1, 0, 0, '0, '0);

      // Branch vectors: pending-ack, coincident-ack, wrap-around targets
      lat = 2;
      for (int k = 0; k < 6; k++) begin
         run_until_req(ok, a);
         fired = 0;
         for (int i = 0; i < 6 && !fired; i++) begin
            tick(1, 0, tv[k].mode, tv[k].bpc, tv[k].bimm);
            fired = saw_br;
         end
         chk("br_fired", 32'(fired), 32'd1);
         run_until_req(ok, a);
         chk("br_target", a, tv[k].exp);
      end
      // Fetch at 0xFFFF_FFFC must be followed by 0x0000_0000
      run_until_req(ok, a);
      chk("pc_wrap", a, 32'd0);

      // Reset while waiting on memory; the late ack must be ignored
      run_until_req(ok, a);
      tick(1, 1, 0, '0, '0);
      tick(1, 0, 0, '0, '0);
      chk("s6_if_valid", 32'(if_valid), 32'd0);
      chk("s6_if_instr", if_instr, 32'd0);
      chk("s6_if_pc", if_pc, 32'd0);
      tick(1, 0, 0, '0, '0);
      chk("s6_if_valid_after_ack", 32'(if_valid), 32'd0);
      chk("s6_if_instr_after_ack", if_instr, 32'd0);
      chk("s6_restart_req", 32'(saw_req), 32'd1);
      chk("s6_restart_addr", req_addr, RST_PC);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         logic [31:0] r, bpc, bimm;
         int bm;
         lat  = int'($urandom_range(3, 1));
         r    = $urandom;
         bpc  = $urandom & 32'hFFFF_FFFC;
         bimm = {{20{r[11]}}, r[11:2], 2'b00};
         bm   = ($urandom_range(29, 0) == 0) ? int'($urandom_range(3, 1)) : 0;
         tick($urandom_range(3, 0) != 0, 0, bm, bpc, bimm);
      end
      for (int i = 0; i < 12; i++) tick(1, 0, 0, '0, '0);
      pcheck = 1;
      tick(1, 0, 0, '0, '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
